// File: rtl/vga_stream_out.sv
// Pixel FIFO replayed against free-running VGA raster timing; registered
// hsync/vsync/de/data outputs and a sticky underflow flag.
module vga_stream_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DEPTH    = 16,
  parameter int PREFILL  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] vga_data,
  output logic       vga_de,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       underflow,
  output logic       running
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [0:0] ST_PREFILL = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          run;
  logic          full;
  logic          empty;
  logic          act;
  logic          push;
  logic          pop;
  logic          h_sync_on;
  logic          v_sync_on;

  assign run       = (state == ST_RUN);
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign act       = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign push      = pix_valid && !full;
  assign pop       = act && !empty;
  assign h_sync_on = run && (int'(h_cnt) >= H_ACTIVE + H_FP)
                         && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign v_sync_on = run && (int'(v_cnt) >= V_ACTIVE + V_FP)
                         && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign pix_ready = !full;
  assign running   = run;

  // Counters sit at zero until the FIFO holds enough to start; once running,
  // the raster never stalls on FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_PREFILL;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      if (level >= LW'(PREFILL)) state <= ST_RUN;
    end else if (int'(h_cnt) == H_TOT - 1) begin
      h_cnt <= '0;
      v_cnt <= (int'(v_cnt) == V_TOT - 1) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_data  <= 8'h00;
      vga_de    <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      underflow <= 1'b0;
    end else begin
      vga_de    <= act;
      vga_data  <= pop ? mem[rd_ptr] : 8'h00;
      vga_hsync <= !h_sync_on;
      vga_vsync <= !v_sync_on;
      if (act && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a tiny 8x5 raster: a cycle-count/queue model
// checked every clock, plus directed literal expectations per scenario.
module tb_vga_stream_out;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_data = 8'h00;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] vga_data;
  logic       vga_de;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       underflow;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  vga_stream_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DEPTH(8), .PREFILL(4)
  ) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .vga_data(vga_data), .vga_de(vga_de),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .underflow(underflow),
    .running(running)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel queue plus a cycle count since the raster started.
  logic [7:0] exp_q[$];
  bit         m_run   = 1'b0;
  int         m_t     = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_de = 1'b0, exp_hs = 1'b1, exp_vs = 1'b1, exp_uf = 1'b0;

  initial begin : model_proc
    int h, v, pre_level;
    bit act, emp, ful;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_run = 1'b0; m_t = 0;
        exp_data = 8'h00; exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_uf = 1'b0;
      end else begin
        h   = m_run ? (m_t % 8) : 0;
        v   = m_run ? ((m_t / 8) % 5) : 0;
        act = m_run && h < 4 && v < 2;
        pre_level = exp_q.size();
        emp = (pre_level == 0);
        ful = (pre_level == 8);
        exp_de   = act;
        exp_data = (act && !emp) ? exp_q[0] : 8'h00;
        if (act && emp) exp_uf = 1'b1;
        exp_hs = !(m_run && h >= 5 && h < 7);
        exp_vs = !(m_run && v == 3);
        if (act && !emp) void'(exp_q.pop_front());
        if (pix_valid && !ful) exp_q.push_back(pix_data);
        if (m_run) m_t++;
        else if (pre_level >= 4) m_run = 1'b1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("de",       {31'd0, vga_de},    {31'd0, exp_de});
      check("data",     {24'd0, vga_data},  {24'd0, exp_data});
      check("hsync",    {31'd0, vga_hsync}, {31'd0, exp_hs});
      check("vsync",    {31'd0, vga_vsync}, {31'd0, exp_vs});
      check("underflow",{31'd0, underflow}, {31'd0, exp_uf});
      check("running",  {31'd0, running},   {31'd0, m_run});
      check("ready",    {31'd0, pix_ready}, {31'd0, (exp_q.size() < 8)});
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_de"},      {31'd0, vga_de},    32'd0);
    check({tag, "_data"},    {24'd0, vga_data},  32'h00);
    check({tag, "_hsync"},   {31'd0, vga_hsync}, 32'd1);
    check({tag, "_vsync"},   {31'd0, vga_vsync}, 32'd1);
    check({tag, "_uf"},      {31'd0, underflow}, 32'd0);
    check({tag, "_running"}, {31'd0, running},   32'd0);
    check({tag, "_ready"},   {31'd0, pix_ready}, 32'd1);
  endtask

  logic [7:0] pre [4] = '{8'h7F, 8'h76, 8'h5B, 8'hA5};
  logic [7:0] re  [4] = '{8'h81, 8'h02, 8'h83, 8'h04};

  initial begin
    int de_n, hs_n, vs_n, uf_n, k;
    // 1 reset
    tick();
    check_en = 1'b1;
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // 2 prefill
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_data = pre[i];
      tick();
      check("prefill_running", {31'd0, running}, 32'd0);
    end
    pix_data = 8'h10;
    tick();
    check("run_start", {31'd0, running}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      pix_data = 8'h11 + 8'(i);
      tick();
      check("first_line_de", {31'd0, vga_de}, 32'd1);
      check("first_line_data", {24'd0, vga_data}, {24'd0, pre[i]});
    end

    // 3 sync timing over exactly one frame with the FIFO kept fed
    de_n = 0; hs_n = 0; vs_n = 0;
    for (int i = 0; i < 40; i++) begin
      pix_data = 8'h20 + 8'(i);
      tick();
      de_n += int'(vga_de);
      hs_n += int'(!vga_hsync);
      vs_n += int'(!vga_vsync);
    end
    check("frame_de_clks", de_n, 32'd8);
    check("frame_hsync_low_clks", hs_n, 32'd10);
    check("frame_vsync_low_clks", vs_n, 32'd8);

    // 5 underflow: starve the FIFO
    pix_valid = 1'b0;
    k = 0;
    while (k < 100 && underflow !== 1'b1) begin tick(); k++; end
    check("underflow_seen", {31'd0, underflow}, 32'd1);
    check("underflow_de", {31'd0, vga_de}, 32'd1);
    check("underflow_data", {24'd0, vga_data}, 32'h00);
    uf_n = 0;
    for (int i = 0; i < 40; i++) begin tick(); uf_n += int'(underflow); end
    check("underflow_sticky", uf_n, 32'd40);

    // 4 full: fill during vertical blanking
    k = 0;
    while (k < 60 && vga_vsync !== 1'b0) begin tick(); k++; end
    check("vblank_reached", {31'd0, vga_vsync}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      check("ready_before_push", {31'd0, pix_ready}, (i < 8) ? 32'd1 : 32'd0);
      pix_valid = 1'b1; pix_data = 8'hE0 + 8'(i);
      tick();
    end
    pix_valid = 1'b0;
    check("ready_when_full", {31'd0, pix_ready}, 32'd0);
    k = 0;
    while (k < 40 && vga_de !== 1'b1) begin tick(); k++; end
    check("full_first_de", {31'd0, vga_de}, 32'd1);
    check("full_oldest_out", {24'd0, vga_data}, 32'hE0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("full_order", {24'd0, vga_data}, 32'hE0 + i);
    end

    // 6 mid-frame reset
    tick();
    k = 0;
    while (k < 40 && vga_de !== 1'b1) begin tick(); k++; end
    check("midframe_active", {31'd0, vga_de}, 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("midreset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1; pix_data = re[i];
      tick();
    end
    pix_valid = 1'b0;
    tick();
    check("rerun_running", {31'd0, running}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rerun_de", {31'd0, vga_de}, 32'd1);
      check("rerun_data", {24'd0, vga_data}, {24'd0, re[i]});
    end
    tick();
    check("rerun_porch_de", {31'd0, vga_de}, 32'd0);
    check("rerun_porch_hsync", {31'd0, vga_hsync}, 32'd1);
    tick();
    check("rerun_hsync_low", {31'd0, vga_hsync}, 32'd0);
    for (int i = 0; i < 6; i++) tick();

    @(negedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
